snn_load_rx: RTL and testbench

// - Clocked receiving end of the SNN host load protocol. Accepts load_start, then filter (addr,data) pairs,

---
 rtl/snn_load_rx.sv | 280 ++++++++++++++++++++++++++++
 tb/tb_snn_load_rx.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/snn_load_rx.sv
// Receive side of the SNN host load protocol: 4-phase channels decoded into RAM writes.
// Define LOAD_CNT_CHECK_EN to add the sticky cnt_err load-count check.
module snn_load_rx #(
    parameter int CH_W    = 18,
    parameter int F_DEPTH = 5,
    parameter int I_DEPTH = 32,
    parameter int N_TS    = 2,
    localparam int F_ENT  = F_DEPTH * F_DEPTH,
    localparam int I_ENT  = I_DEPTH * I_DEPTH,
    localparam int FAW    = $clog2(F_ENT),
    localparam int IAW    = $clog2(I_ENT),
    localparam int TSW    = (N_TS > 1) ? $clog2(N_TS) : 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            ld_start_req,
    output logic            ld_start_ack,
    input  logic [CH_W-1:0] ld_start_data,
    input  logic            f_addr_req,
    output logic            f_addr_ack,
    input  logic [CH_W-1:0] f_addr_data,
    input  logic            f_data_req,
    output logic            f_data_ack,
    input  logic [CH_W-1:0] f_data_data,
    input  logic            ts_req,
    output logic            ts_ack,
    input  logic [CH_W-1:0] ts_data,
    input  logic            i_addr_req,
    output logic            i_addr_ack,
    input  logic [CH_W-1:0] i_addr_data,
    input  logic            i_data_req,
    output logic            i_data_ack,
    input  logic [CH_W-1:0] i_data_data,
    input  logic            ld_done_req,
    output logic            ld_done_ack,
    input  logic [CH_W-1:0] ld_done_data,
    output logic            fw_en,
    output logic [FAW-1:0]  fw_addr,
    output logic [7:0]      fw_data,
    output logic            iw_en,
    output logic [TSW-1:0]  iw_ts,
    output logic [IAW-1:0]  iw_addr,
    output logic            iw_data,
    output logic            load_busy,
    output logic            load_complete,
    output logic            addr_err
`ifdef LOAD_CNT_CHECK_EN
    ,
    output logic            cnt_err
`endif
);

    localparam logic [11:0] F_LIM = 12'(F_ENT);
    localparam logic [11:0] I_LIM = 12'(I_ENT);
    localparam logic [11:0] I_TOT = 12'(N_TS * I_ENT);

    typedef enum logic [2:0] {
        S_IDLE, S_FADDR, S_FDATA, S_ITS, S_IADDR, S_IDATA, S_DONE
    } state_e;

    typedef enum logic [2:0] {
        C_ST, C_FA, C_FD, C_TS, C_IA, C_ID, C_DN
    } chan_e;

    state_e state_q, state_d, nxt_q, nxt_d;
    chan_e  ch_q, ch_d;
    logic ack_q, ack_d, req_sel;
    logic [11:0] fcnt_q, fcnt_d, icnt_q, icnt_d;
    logic [11:0] fa_q, fa_d, ia_q, ia_d;
    logic [1:0] ts_q, ts_d;
    logic ts_ok;
    logic fw_en_q, fw_en_d, iw_en_q, iw_en_d;
    logic [FAW-1:0] fw_addr_q, fw_addr_d;
    logic [7:0] fw_data_q, fw_data_d;
    logic [TSW-1:0] iw_ts_q, iw_ts_d;
    logic [IAW-1:0] iw_addr_q, iw_addr_d;
    logic iw_data_q, iw_data_d;
    logic busy_q, busy_d, cmpl_q, cmpl_d, err_q, err_d;
`ifdef LOAD_CNT_CHECK_EN
    logic cerr_q, cerr_d;
`endif

    logic unused_data;
    assign unused_data = ^{ld_start_data[CH_W-1:1], f_addr_data[CH_W-1:12],
                           f_data_data[CH_W-1:8], ts_data[CH_W-1:2],
                           i_addr_data[CH_W-1:12], i_data_data[CH_W-1:1],
                           ld_done_data};

    assign ts_ok = (ts_q != 2'd0) && (int'(ts_q) <= N_TS);

    always_comb begin
        unique case (ch_q)
            C_ST:    req_sel = ld_start_req;
            C_FA:    req_sel = f_addr_req;
            C_FD:    req_sel = f_data_req;
            C_TS:    req_sel = ts_req;
            C_IA:    req_sel = i_addr_req;
            C_ID:    req_sel = i_data_req;
            C_DN:    req_sel = ld_done_req;
            default: req_sel = 1'b0;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        nxt_d     = nxt_q;
        ch_d      = ch_q;
        ack_d     = ack_q;
        fcnt_d    = fcnt_q;
        icnt_d    = icnt_q;
        fa_d      = fa_q;
        ia_d      = ia_q;
        ts_d      = ts_q;
        fw_en_d   = 1'b0;
        iw_en_d   = 1'b0;
        fw_addr_d = fw_addr_q;
        fw_data_d = fw_data_q;
        iw_ts_d   = iw_ts_q;
        iw_addr_d = iw_addr_q;
        iw_data_d = iw_data_q;
        busy_d    = busy_q;
        cmpl_d    = cmpl_q;
        err_d     = err_q;
`ifdef LOAD_CNT_CHECK_EN
        cerr_d    = cerr_q;
        if (f_addr_req && fcnt_q == F_LIM &&
            (state_q == S_ITS || state_q == S_IADDR || state_q == S_IDATA))
            cerr_d = 1'b1;
`endif
        // The state only moves once the sender has dropped req and ack falls.
        if (ack_q) begin
            if (!req_sel) begin
                ack_d   = 1'b0;
                state_d = nxt_q;
            end
        end else begin
            unique case (state_q)
                S_IDLE, S_DONE: if (ld_start_req) begin
                    ack_d = 1'b1;
                    ch_d  = C_ST;
                    nxt_d = state_q;
                    if (ld_start_data[0]) begin
                        nxt_d  = S_FADDR;
                        fcnt_d = '0;
                        icnt_d = '0;
                        busy_d = 1'b1;
                        cmpl_d = 1'b0;
                    end
                end
                S_FADDR: if (f_addr_req) begin
                    ack_d = 1'b1;
                    ch_d  = C_FA;
                    nxt_d = S_FDATA;
                    fa_d  = f_addr_data[11:0];
                    if (f_addr_data[11:0] >= F_LIM) err_d = 1'b1;
                end
                S_FDATA: if (f_data_req) begin
                    ack_d  = 1'b1;
                    ch_d   = C_FD;
                    fcnt_d = fcnt_q + 12'd1;
                    nxt_d  = (fcnt_q + 12'd1 == F_LIM) ? S_ITS : S_FADDR;
                    if (fa_q < F_LIM) begin
                        fw_en_d   = 1'b1;
                        fw_addr_d = fa_q[FAW-1:0];
                        fw_data_d = f_data_data[7:0];
                    end
                end
                S_ITS: if (ts_req) begin
                    ack_d = 1'b1;
                    ch_d  = C_TS;
                    nxt_d = S_IADDR;
                    ts_d  = ts_data[1:0];
                    if (ts_data[1:0] == 2'd0 || int'(ts_data[1:0]) > N_TS)
                        err_d = 1'b1;
                end else if (ld_done_req) begin
                    ack_d  = 1'b1;
                    ch_d   = C_DN;
                    nxt_d  = S_DONE;
                    busy_d = 1'b0;
                    cmpl_d = 1'b1;
`ifdef LOAD_CNT_CHECK_EN
                    if (icnt_q != I_TOT) cerr_d = 1'b1;
`endif
                end
                S_IADDR: if (i_addr_req) begin
                    ack_d = 1'b1;
                    ch_d  = C_IA;
                    nxt_d = S_IDATA;
                    ia_d  = i_addr_data[11:0];
                    if (i_addr_data[11:0] >= I_LIM) err_d = 1'b1;
                end
                S_IDATA: if (i_data_req) begin
                    ack_d  = 1'b1;
                    ch_d   = C_ID;
                    nxt_d  = S_ITS;
                    icnt_d = icnt_q + 12'd1;
                    if (ts_ok && ia_q < I_LIM) begin
                        iw_en_d   = 1'b1;
                        iw_ts_d   = TSW'(ts_q - 2'd1);
                        iw_addr_d = ia_q[IAW-1:0];
                        iw_data_d = i_data_data[0];
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            nxt_q     <= S_IDLE;
            ch_q      <= C_ST;
            ack_q     <= 1'b0;
            fcnt_q    <= '0;
            icnt_q    <= '0;
            fa_q      <= '0;
            ia_q      <= '0;
            ts_q      <= '0;
            fw_en_q   <= 1'b0;
            iw_en_q   <= 1'b0;
            fw_addr_q <= '0;
            fw_data_q <= '0;
            iw_ts_q   <= '0;
            iw_addr_q <= '0;
            iw_data_q <= 1'b0;
            busy_q    <= 1'b0;
            cmpl_q    <= 1'b0;
            err_q     <= 1'b0;
`ifdef LOAD_CNT_CHECK_EN
            cerr_q    <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            nxt_q     <= nxt_d;
            ch_q      <= ch_d;
            ack_q     <= ack_d;
            fcnt_q    <= fcnt_d;
            icnt_q    <= icnt_d;
            fa_q      <= fa_d;
            ia_q      <= ia_d;
            ts_q      <= ts_d;
            fw_en_q   <= fw_en_d;
            iw_en_q   <= iw_en_d;
            fw_addr_q <= fw_addr_d;
            fw_data_q <= fw_data_d;
            iw_ts_q   <= iw_ts_d;
            iw_addr_q <= iw_addr_d;
            iw_data_q <= iw_data_d;
            busy_q    <= busy_d;
            cmpl_q    <= cmpl_d;
            err_q     <= err_d;
`ifdef LOAD_CNT_CHECK_EN
            cerr_q    <= cerr_d;
`endif
        end
    end

    assign ld_start_ack  = ack_q && (ch_q == C_ST);
    assign f_addr_ack    = ack_q && (ch_q == C_FA);
    assign f_data_ack    = ack_q && (ch_q == C_FD);
    assign ts_ack        = ack_q && (ch_q == C_TS);
    assign i_addr_ack    = ack_q && (ch_q == C_IA);
    assign i_data_ack    = ack_q && (ch_q == C_ID);
    assign ld_done_ack   = ack_q && (ch_q == C_DN);
    assign fw_en         = fw_en_q;
    assign fw_addr       = fw_addr_q;
    assign fw_data       = fw_data_q;
    assign iw_en         = iw_en_q;
    assign iw_ts         = iw_ts_q;
    assign iw_addr       = iw_addr_q;
    assign iw_data       = iw_data_q;
    assign load_busy     = busy_q;
    assign load_complete = cmpl_q;
    assign addr_err      = err_q;
`ifdef LOAD_CNT_CHECK_EN
    assign cnt_err       = cerr_q;
`endif

endmodule

// File: tb/tb_snn_load_rx.sv
// Random-stimulus bench for snn_load_rx: a token-level sender plus a queue
// model of the filter/ifmap writes the load must produce.
module tb_snn_load_rx;

    localparam int ST = 0, FA = 1, FD = 2, TS = 3, IA = 4, ID = 5, DN = 6;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [6:0]  req;
    logic [17:0] dat [7];
    wire  [6:0]  ack;
    wire         fw_en, iw_en, iw_data, iw_ts;
    wire  [4:0]  fw_addr;
    wire  [7:0]  fw_data;
    wire  [9:0]  iw_addr;
    wire         load_busy, load_complete, addr_err;
`ifdef LOAD_CNT_CHECK_EN
    wire         cnt_err;
`endif

    snn_load_rx dut (
        .clk(clk), .rst_n(rst_n),
        .ld_start_req(req[ST]), .ld_start_ack(ack[ST]), .ld_start_data(dat[ST]),
        .f_addr_req(req[FA]),   .f_addr_ack(ack[FA]),   .f_addr_data(dat[FA]),
        .f_data_req(req[FD]),   .f_data_ack(ack[FD]),   .f_data_data(dat[FD]),
        .ts_req(req[TS]),       .ts_ack(ack[TS]),       .ts_data(dat[TS]),
        .i_addr_req(req[IA]),   .i_addr_ack(ack[IA]),   .i_addr_data(dat[IA]),
        .i_data_req(req[ID]),   .i_data_ack(ack[ID]),   .i_data_data(dat[ID]),
        .ld_done_req(req[DN]),  .ld_done_ack(ack[DN]),  .ld_done_data(dat[DN]),
        .fw_en(fw_en), .fw_addr(fw_addr), .fw_data(fw_data),
        .iw_en(iw_en), .iw_ts(iw_ts), .iw_addr(iw_addr), .iw_data(iw_data),
        .load_busy(load_busy), .load_complete(load_complete), .addr_err(addr_err)
`ifdef LOAD_CNT_CHECK_EN
        , .cnt_err(cnt_err)
`endif
    );

    int vectors = 0;
    int miscompares = 0;
    logic [12:0] fwq [$];
    logic [11:0] iwq [$];
    bit model_err = 1'b0;

    task automatic check(input string name, input logic [31:0] got,
                         input logic [31:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s: got %0h want %0h", name, got, want);
        end
    endtask

    task automatic finish_tok(input int c);
        int n;
        n = 0;
        while (ack[c] !== 1'b1 && n < 100) begin
            @(posedge clk); #1; n++;
        end
        check($sformatf("ack_rise_ch%0d", c), ack[c], 1'b1);
        req[c] = 1'b0;
        n = 0;
        while (ack[c] !== 1'b0 && n < 100) begin
            @(posedge clk); #1; n++;
        end
        check($sformatf("ack_fall_ch%0d", c), ack[c], 1'b0);
    endtask

    task automatic send(input int c, input logic [17:0] d);
        dat[c] = d;
        req[c] = 1'b1;
        finish_tok(c);
    endtask

    task automatic fpair(input logic [11:0] a, input logic [7:0] d);
        send(FA, 18'(a));
        if (a < 12'd25) fwq.push_back({a[4:0], d});
        else model_err = 1'b1;
        send(FD, {10'h3ff, d});
    endtask

    task automatic triple(input logic [1:0] t, input logic [11:0] a,
                          input logic s);
        logic [1:0] tm;
        send(TS, {16'hbeef, t});
        if (t == 2'd0 || t > 2'd2) model_err = 1'b1;
        send(IA, 18'(a));
        if (a >= 12'd1024) model_err = 1'b1;
        tm = t - 2'd1;
        if (t != 2'd0 && t <= 2'd2 && a < 12'd1024)
            iwq.push_back({tm[0], a[9:0], s});
        send(ID, {17'h1aaaa, s});
    endtask

    always @(negedge clk) begin
        logic [12:0] fe;
        logic [11:0] ie;
        if (rst_n) begin
            if (fw_en === 1'b1) begin
                if (fwq.size() == 0) check("fw_en_unexpected", fw_en, 1'b0);
                else begin
                    fe = fwq.pop_front();
                    check("fw_write", {fw_addr, fw_data}, fe);
                end
            end
            if (iw_en === 1'b1) begin
                if (iwq.size() == 0) check("iw_en_unexpected", iw_en, 1'b0);
                else begin
                    ie = iwq.pop_front();
                    check("iw_write", {iw_ts, iw_addr, iw_data}, ie);
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic s;
        req = '0;
        for (int i = 0; i < 7; i++) dat[i] = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_acks", ack, 7'd0);
        check("rst_fw_en", fw_en, 1'b0);
        check("rst_iw_en", iw_en, 1'b0);
        check("rst_busy", load_busy, 1'b0);
        check("rst_complete", load_complete, 1'b0);
        check("rst_err", addr_err, 1'b0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        send(ST, 18'h3fffe);
        check("start0_busy", load_busy, 1'b0);
        send(ST, 18'd1);
        check("start_busy", load_busy, 1'b1);
        check("start_complete", load_complete, 1'b0);

        dat[TS] = 18'd1;
        req[TS] = 1'b1;
        for (int i = 0; i < 25; i++) begin
            if (i == 24) begin
                dat[DN] = 18'd1;
                req[DN] = 1'b1;
            end
            fpair(12'(i), 8'(i + 3));
            check("ts_backpressure", ack[TS], 1'b0);
            if (i == 0) check("fw_pin0", {fw_addr, fw_data}, {5'd0, 8'd3});
        end
        check("fw_pin24", {fw_addr, fw_data}, {5'd24, 8'd27});
        finish_tok(TS);
        check("done_pending", ack[DN], 1'b0);
        req[DN] = 1'b0;
        send(IA, 18'd0);
        s = 1'($urandom);
        iwq.push_back({1'b0, 10'd0, s});
        send(ID, 18'(s));
        check("iw_ts_pin0", iw_ts, 1'b0);
        for (int j = 1; j < 1024; j++) triple(2'd1, 12'(j), 1'($urandom));
        triple(2'd2, 12'd0, 1'($urandom));
        check("iw_ts_pin1", iw_ts, 1'b1);
        for (int j = 1; j < 1024; j++) triple(2'd2, 12'(j), 1'($urandom));
        check("nom_busy_mid", load_busy, 1'b1);
        send(DN, 18'd1);
        check("nom_busy", load_busy, 1'b0);
        check("nom_complete", load_complete, 1'b1);
        check("nom_err", addr_err, 1'b0);
`ifdef LOAD_CNT_CHECK_EN
        check("nom_cnt_err", cnt_err, 1'b0);
`endif
        check("nom_fwq_drained", fwq.size(), 0);
        check("nom_iwq_drained", iwq.size(), 0);

        send(ST, 18'd1);
        check("err_complete_clr", load_complete, 1'b0);
        check("err_busy", load_busy, 1'b1);
        fpair(12'd30, 8'd7);
        check("err_faddr30", addr_err, 1'b1);
        for (int i = 1; i < 25; i++) begin
            fpair(12'($urandom_range(0, 40)), 8'($urandom));
            check("err_sticky_f", addr_err, model_err);
        end
        triple(2'd3, 12'd5, 1'b1);
        check("err_ts3", addr_err, 1'b1);
        for (int j = 0; j < 60; j++) begin
            triple(2'($urandom_range(0, 3)), 12'($urandom_range(0, 1100)),
                   1'($urandom));
            check("err_sticky_i", addr_err, model_err);
        end
        send(DN, 18'd1);
        check("err_complete", load_complete, 1'b1);
`ifdef LOAD_CNT_CHECK_EN
        check("err_cnt_err", cnt_err, 1'b1);
`endif
        check("err_fwq_drained", fwq.size(), 0);
        check("err_iwq_drained", iwq.size(), 0);

        send(ST, 18'd1);
        for (int i = 0; i < 25; i++) fpair(12'(i), 8'($urandom));
        send(TS, 18'd1);
        send(IA, 18'd7);
        dat[ID] = 18'd1;
        req[ID] = 1'b1;
        for (int n = 0; n < 100 && ack[ID] !== 1'b1; n++) begin
            @(posedge clk); #1;
        end
        check("mid_ack_up", ack[ID], 1'b1);
        rst_n = 1'b0;
        req = '0;
        #1;
        check("mid_rst_acks", ack, 7'd0);
        check("mid_rst_busy", load_busy, 1'b0);
        check("mid_rst_iw_en", iw_en, 1'b0);
        check("mid_rst_err", addr_err, 1'b0);
        fwq.delete();
        iwq.delete();
        model_err = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        send(ST, 18'd1);
        for (int i = 0; i < 25; i++)
            fpair(12'($urandom_range(0, 24)), 8'($urandom));
        for (int j = 0; j < 30; j++)
            triple(2'($urandom_range(1, 2)), 12'($urandom_range(0, 1023)),
                   1'($urandom));
        send(DN, 18'd1);
        check("fresh_complete", load_complete, 1'b1);
        check("fresh_busy", load_busy, 1'b0);
        check("fresh_err", addr_err, 1'b0);
        check("fresh_fwq_drained", fwq.size(), 0);
        check("fresh_iwq_drained", iwq.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors,
                 miscompares);
        $finish;
    end

endmodule
